hazard_controller: RTL and testbench
====================================

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 Clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 Reset  input  1  synchronous, active-high reset.
REQ-003 ID_Rs, ID_Rt  input  5 each  source registers of the instruction held in the IF/ID stage register.
REQ-004 ID_UsesRt  input  1  instruction in ID reads Rt as a source.
REQ-005 ID_IsBranch  input  1  instruction in ID is a conditional branch; branches compare operands in ID.
REQ-006 EX_MemRead, EX_RegWrite  input  1 each  ID/EX-stage load and register-write flags.
REQ-007 EX_WriteReg  input  5  ID/EX-stage destination register.
REQ-008 MEM_MemRead  input  1  EX/MEM-stage load flag.
REQ-009 MEM_WriteReg  input  5  EX/MEM-stage destination register.
REQ-010 BranchTaken, Jump  input  1 each  redirect resolved in ID this cycle.
REQ-011 PCWrite  output  1  PC update enable.
REQ-012 IFIDWrite  output  1  drives the IF/ID register Write input.
REQ-013 IFIDFlush  output  1  drives the IF/ID register flushControl input.
REQ-014 IDEXBubble  output  1  zeroes ID/EX control signals (inserts a NOP).
REQ-015 StallCount  output  16  saturating count of stall cycles.

Function
REQ-016 match(a,b) SHALL be true only when a==b and b!=0; register 0 never causes a hazard.
REQ-017 srcHit(r) SHALL be match(ID_Rs,r) OR (ID_UsesRt AND match(ID_Rt,r)).
REQ-018 Stall demand N SHALL be computed by the first applicable rule:
  - ID_IsBranch AND EX_MemRead AND srcHit(EX_WriteReg) -> 2.
  - EX_MemRead AND srcHit(EX_WriteReg) -> 1.
  - ID_IsBranch AND EX_RegWrite AND srcHit(EX_WriteReg) -> 1.
  - ID_IsBranch AND MEM_MemRead AND srcHit(MEM_WriteReg) -> 1.
  - Otherwise -> 0.
REQ-019 FSM states SHALL be RUN, STALL1 and STALL2; the state is the number of further stall cycles still owed.
REQ-020 In RUN with N>0, outputs SHALL be combinational in the same cycle: PCWrite=0, IFIDWrite=0, IDEXBubble=1, IFIDFlush=0.
REQ-021 RUN transitions: N=2 -> STALL1; N=1 or N=0 -> RUN.
REQ-022 In STALL1, the block SHALL stall unconditionally (REQ-020 outputs), ignore all hazard and redirect inputs, and go to RUN.
REQ-023 STALL2 SHALL be encoded for N=3 extensions, shall behave like STALL1, and shall transition to STALL1; the current rules never enter it.
REQ-024 In RUN with N=0 and (BranchTaken OR Jump), outputs SHALL be IFIDFlush=1, PCWrite=1, IFIDWrite=1, IDEXBubble=0 for exactly that cycle.
REQ-025 A stall SHALL take priority over a redirect; BranchTaken and Jump are ignored while stalling.
REQ-026 IFIDFlush and IFIDWrite=0 SHALL never be asserted together.
REQ-027 In RUN with N=0 and no redirect, outputs SHALL be PCWrite=1, IFIDWrite=1, IFIDFlush=0, IDEXBubble=0.
REQ-028 StallCount SHALL increment by 1 on each clock edge where IDEXBubble=1, and SHALL hold at 0xFFFF once reached.

Reset
REQ-029 While Reset=1, outputs SHALL be PCWrite=1, IFIDWrite=1, IFIDFlush=0, IDEXBubble=0, regardless of the other inputs.
REQ-030 On a Reset edge, state SHALL become RUN and StallCount SHALL become 0.
REQ-031 Reset asserted during STALL1 or STALL2 SHALL abandon the remaining stall cycles.

Structure
REQ-032 Shared package hazard_pkg SHALL hold the state encoding (RUN, STALL1, STALL2), REG_ZERO=5'd0 and STALL_CNT_W=16.
REQ-033 A single sub-module hazard_match SHALL implement REQ-016/017, instantiated once for EX_WriteReg and once for MEM_WriteReg.
REQ-034 The FSM and StallCount SHALL be the only registers; all outputs are decoded from the state plus the current inputs.

Verification
REQ-035 Load-use: EX_MemRead=1, EX_WriteReg=8, ID_Rs=8 -> one cycle of PCWrite=0, IFIDWrite=0, IDEXBubble=1; next cycle all-run; StallCount=1.
REQ-036 Load then branch: EX_MemRead=1, EX_WriteReg=9, ID_IsBranch=1, ID_Rt=9, ID_UsesRt=1 -> exactly 2 stall cycles (RUN -> STALL1 -> RUN); BranchTaken=1 in the 2nd cycle is ignored.
REQ-037 Register zero: EX_MemRead=1, EX_WriteReg=0, ID_Rs=0 -> no stall; StallCount unchanged.
REQ-038 Redirect: Jump=1 with no hazard -> IFIDFlush=1 and PCWrite=1 for one cycle; hazard plus BranchTaken=1 in the same cycle -> stall only, IFIDFlush=0.
REQ-039 Reset mid-stall: Reset=1 in the STALL1 cycle -> outputs all-run and the next state is RUN; StallCount=0.
REQ-040 Saturation: force 65536 stall cycles -> StallCount holds at 0xFFFF.

Source files
------------

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// hazard_pkg: shared state encoding and constants for the hazard controller.
// Revision: 1.0
// ============================================================================
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL1 = 2'd1,
        STALL2 = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO    = 5'd0;
    localparam int         STALL_CNT_W = 16;

    // Register zero is hard-wired, so it can never create a dependency.
    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a == b) && (b != REG_ZERO);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_match.sv
`default_nettype none
// ============================================================================
// hazard_match: flags whether the ID instruction sources a given write register.
// Revision: 1.0
// ============================================================================
module hazard_match
    import hazard_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       uses_rt,
    input  logic [4:0] wreg,
    output logic       hit
);

    assign hit = reg_match(rs, wreg) || (uses_rt && reg_match(rt, wreg));

endmodule
`default_nettype wire

// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
// hazard_controller: load-use / branch-operand stall FSM with redirect flush.
// Revision: 1.0
// ============================================================================
module hazard_controller
    import hazard_pkg::*;
(
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [4:0]             ID_Rs,
    input  logic [4:0]             ID_Rt,
    input  logic                   ID_UsesRt,
    input  logic                   ID_IsBranch,
    input  logic                   EX_MemRead,
    input  logic                   EX_RegWrite,
    input  logic [4:0]             EX_WriteReg,
    input  logic                   MEM_MemRead,
    input  logic [4:0]             MEM_WriteReg,
    input  logic                   BranchTaken,
    input  logic                   Jump,
    output logic                   PCWrite,
    output logic                   IFIDWrite,
    output logic                   IFIDFlush,
    output logic                   IDEXBubble,
    output logic [STALL_CNT_W-1:0] StallCount
);

    state_t     state, state_next;
    logic       ex_hit, mem_hit;
    logic [1:0] demand;

    hazard_match u_match_ex (
        .rs      (ID_Rs),
        .rt      (ID_Rt),
        .uses_rt (ID_UsesRt),
        .wreg    (EX_WriteReg),
        .hit     (ex_hit)
    );

    hazard_match u_match_mem (
        .rs      (ID_Rs),
        .rt      (ID_Rt),
        .uses_rt (ID_UsesRt),
        .wreg    (MEM_WriteReg),
        .hit     (mem_hit)
    );

    // Branches resolve in ID, so they also wait on ALU results and late loads.
    always_comb begin
        demand = 2'd0;
        if (ID_IsBranch && EX_MemRead && ex_hit)
            demand = 2'd2;
        else if (EX_MemRead && ex_hit)
            demand = 2'd1;
        else if (ID_IsBranch && EX_RegWrite && ex_hit)
            demand = 2'd1;
        else if (ID_IsBranch && MEM_MemRead && mem_hit)
            demand = 2'd1;
    end

    always_ff @(posedge Clk) begin
        if (Reset)
            state <= RUN;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXBubble = 1'b0;
        if (Reset) begin
            state_next = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (demand != 2'd0) begin
                        PCWrite    = 1'b0;
                        IFIDWrite  = 1'b0;
                        IDEXBubble = 1'b1;
                        state_next = (demand == 2'd2) ? STALL1 : RUN;
                    end else if (BranchTaken || Jump) begin
                        IFIDFlush  = 1'b1;
                    end
                end
                STALL1: begin
                    PCWrite    = 1'b0;
                    IFIDWrite  = 1'b0;
                    IDEXBubble = 1'b1;
                    state_next = RUN;
                end
                STALL2: begin
                    PCWrite    = 1'b0;
                    IFIDWrite  = 1'b0;
                    IDEXBubble = 1'b1;
                    state_next = STALL1;
                end
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset)
            StallCount <= '0;
        else if (IDEXBubble && (StallCount != {STALL_CNT_W{1'b1}}))
            StallCount <= StallCount + 1'b1;
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// ============================================================================
// tb_hazard_controller: directed vectors with a queued scoreboard and monitor.
// Revision: 1.0
// ============================================================================
module tb_hazard_controller;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [4:0]  ID_Rs = '0, ID_Rt = '0, EX_WriteReg = '0, MEM_WriteReg = '0;
    logic        ID_UsesRt = 1'b0, ID_IsBranch = 1'b0, EX_MemRead = 1'b0;
    logic        EX_RegWrite = 1'b0, MEM_MemRead = 1'b0, BranchTaken = 1'b0, Jump = 1'b0;
    logic        PCWrite, IFIDWrite, IFIDFlush, IDEXBubble;
    logic [15:0] StallCount;

    typedef struct {
        string       nm;
        logic [3:0]  outs;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble}
    localparam logic [3:0] O_RUN   = 4'b1100;
    localparam logic [3:0] O_STALL = 4'b0001;
    localparam logic [3:0] O_FLUSH = 4'b1110;

    hazard_controller dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .ID_Rs        (ID_Rs),
        .ID_Rt        (ID_Rt),
        .ID_UsesRt    (ID_UsesRt),
        .ID_IsBranch  (ID_IsBranch),
        .EX_MemRead   (EX_MemRead),
        .EX_RegWrite  (EX_RegWrite),
        .EX_WriteReg  (EX_WriteReg),
        .MEM_MemRead  (MEM_MemRead),
        .MEM_WriteReg (MEM_WriteReg),
        .BranchTaken  (BranchTaken),
        .Jump         (Jump),
        .PCWrite      (PCWrite),
        .IFIDWrite    (IFIDWrite),
        .IFIDFlush    (IFIDFlush),
        .IDEXBubble   (IDEXBubble),
        .StallCount   (StallCount)
    );

    always #5 Clk = ~Clk;

    task automatic step(input string nm, input logic rst,
                        input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                        input logic br, input logic emr, input logic erw, input logic [4:0] ewr,
                        input logic mmr, input logic [4:0] mwr, input logic bt, input logic jp,
                        input logic [3:0] eo, input logic [15:0] ec, input logic chk);
        exp_t e;
        @(posedge Clk);
        #1;
        Reset = rst; ID_Rs = rs; ID_Rt = rt; ID_UsesRt = ur; ID_IsBranch = br;
        EX_MemRead = emr; EX_RegWrite = erw; EX_WriteReg = ewr;
        MEM_MemRead = mmr; MEM_WriteReg = mwr; BranchTaken = bt; Jump = jp;
        if (chk) begin
            e.nm = nm; e.outs = eo; e.cnt = ec;
            q.push_back(e);
        end
    endtask

    task automatic idle(input string nm, input logic [15:0] ec);
        step(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, ec, 1);
    endtask

    // Monitor: outputs are combinational, so each queued entry is checked mid-cycle.
    initial begin
        exp_t       e;
        logic [3:0] act;
        forever begin
            @(negedge Clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble};
                n_cmp++;
                if (act !== e.outs || StallCount !== e.cnt) begin
                    n_bad++;
                    $display("FAIL %s: got outs=%b cnt=%h, want outs=%b cnt=%h",
                             e.nm, act, StallCount, e.outs, e.cnt);
                end
                n_cmp++;
                if (IFIDFlush && !IFIDWrite) begin
                    n_bad++;
                    $display("FAIL %s_flush_vs_hold: got flush=%b ifidwrite=%b, want not both flush and hold",
                             e.nm, IFIDFlush, IFIDWrite);
                end
            end
        end
    end

    initial begin
        int waited;
        //    name             rst rs  rt  ur br emr erw ewr mmr mwr bt jp outs     cnt
        step("reset_override",  1, 8,  0,  0, 0, 1,  0,  8,  0,  0,  0, 0, O_RUN,   16'd0, 1);
        idle("idle",            16'd0);
        step("loaduse_stall",   0, 8,  0,  0, 0, 1,  0,  8,  0,  0,  0, 0, O_STALL, 16'd0, 1);
        idle("loaduse_after",   16'd1);
        step("ldbr_stall1",     0, 0,  9,  1, 1, 1,  0,  9,  0,  0,  0, 0, O_STALL, 16'd1, 1);
        step("ldbr_stall2_bt",  0, 0,  0,  0, 0, 0,  0,  0,  0,  0,  1, 0, O_STALL, 16'd2, 1);
        idle("ldbr_after",      16'd3);
        step("reg_zero",        0, 0,  0,  0, 0, 1,  0,  0,  0,  0,  0, 0, O_RUN,   16'd3, 1);
        step("rt_unused",       0, 1,  5,  0, 0, 1,  0,  5,  0,  0,  0, 0, O_RUN,   16'd3, 1);
        step("jump_flush",      0, 0,  0,  0, 0, 0,  0,  0,  0,  0,  0, 1, O_FLUSH, 16'd3, 1);
        step("stall_over_bt",   0, 8,  0,  0, 0, 1,  0,  8,  0,  0,  1, 0, O_STALL, 16'd3, 1);
        idle("after_stall_bt",  16'd4);
        step("br_ex_regwrite",  0, 3,  0,  0, 1, 0,  1,  3,  0,  0,  0, 0, O_STALL, 16'd4, 1);
        idle("after_br_ex",     16'd5);
        step("alu_fwd_nostall", 0, 3,  0,  0, 0, 0,  1,  3,  0,  0,  0, 0, O_RUN,   16'd5, 1);
        step("br_mem_load",     0, 7,  0,  0, 1, 0,  0,  0,  1,  7,  0, 0, O_STALL, 16'd5, 1);
        idle("after_br_mem",    16'd6);
        step("mem_load_nobr",   0, 7,  0,  0, 0, 0,  0,  0,  1,  7,  0, 0, O_RUN,   16'd6, 1);
        step("ldbr_again",      0, 0,  9,  1, 1, 1,  0,  9,  0,  0,  0, 0, O_STALL, 16'd6, 1);
        step("reset_in_stall1", 1, 0,  0,  0, 0, 0,  0,  0,  0,  0,  0, 0, O_RUN,   16'd7, 1);
        step("run_after_reset", 0, 0,  0,  0, 0, 0,  0,  0,  0,  0,  0, 1, O_FLUSH, 16'd0, 1);
        step("bt_flush",        0, 0,  0,  0, 0, 0,  0,  0,  0,  0,  1, 0, O_FLUSH, 16'd0, 1);
        for (int i = 0; i < 65534; i++)
            step("sat_fill",    0, 8,  0,  0, 0, 1,  0,  8,  0,  0,  0, 0, O_STALL, 16'd0, 0);
        step("sat_fffe",        0, 8,  0,  0, 0, 1,  0,  8,  0,  0,  0, 0, O_STALL, 16'hFFFE, 1);
        step("sat_ffff",        0, 8,  0,  0, 0, 1,  0,  8,  0,  0,  0, 0, O_STALL, 16'hFFFF, 1);
        step("sat_hold",        0, 8,  0,  0, 0, 1,  0,  8,  0,  0,  0, 0, O_STALL, 16'hFFFF, 1);
        idle("sat_idle",        16'hFFFF);

        waited = 0;
        while (q.size() > 0 && waited < 10) begin
            @(posedge Clk);
            waited++;
        end
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d entries pending, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
